pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It replaces the fixed one-load-delay hazard detector and the two-source forwarding unit.
- Keeps a shift-register scoreboard of in-flight destination registers across NUM_STAGES post-decode stages (stage 1 = EX, stage 2 = MEM, ..., stage NUM_STAGES = WB).
- From the scoreboard it produces the decode stall and registered EX-stage forward selects.
- Supports a configurable load latency, so deeper data memories need no datapath rework.

---
 rtl/pipe_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: shift-register scoreboard of in-flight writers drives the
// decode stall and registered EX forward selects. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int RF_ADDRESS = 5,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [RF_ADDRESS-1:0] id_rs1,
    input  logic [RF_ADDRESS-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [RF_ADDRESS-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_is_load,
    input  logic                  flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events,
`endif
    output logic                  stall,
    output logic [SEL_W-1:0]      ex_fwd_a,
    output logic [SEL_W-1:0]      ex_fwd_b,
    output logic [NUM_STAGES-1:0] inflight
);

    // Scoreboard: index 0 is stage 1 (EX), index NUM_STAGES-1 is WB.
    logic [NUM_STAGES-1:0] v_q;
    logic [NUM_STAGES-1:0] ld_q;
    logic [RF_ADDRESS-1:0] rd_q [NUM_STAGES];

    logic [SEL_W-1:0]      ex_fwd_a_q, ex_fwd_b_q;

    logic [RF_ADDRESS-1:0] src [2];
    logic [1:0]            src_used;
    logic [1:0]            hazard;
    logic [1:0]            found;
    logic [SEL_W-1:0]      sel_d [2];
    logic                  bubble;
    logic                  ins_v_d;

    assign src[0]      = id_rs1;
    assign src[1]      = id_rs2;
    assign src_used[0] = id_rs1_used;
    assign src_used[1] = id_rs2_used;

    // NOTE: every output of this block gets a default before the loops so no latch is inferred.
    always_comb begin
        hazard = '0;
        found  = '0;
        for (int i = 0; i < 2; i++) begin
            sel_d[i] = '0;
            if (src_used[i] && (src[i] != '0)) begin
                for (int s = 1; s <= NUM_STAGES; s++) begin
                    if (!found[i] && v_q[s-1] && (rd_q[s-1] == src[i])) begin
                        found[i] = 1'b1;
                        // A writer already in WB retires before the consumer reaches EX.
                        if (s < NUM_STAGES) sel_d[i] = SEL_W'(s + 1);
                        if ((s + 1) < (ld_q[s-1] ? (2 + LOAD_LAT) : 2)) hazard[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall   = (|hazard) & id_valid & ~flush;
    assign bubble  = stall | flush;
    assign ins_v_d = id_valid & id_regwrite & (id_rd != '0) & ~bubble;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            v_q        <= '0;
            ex_fwd_a_q <= '0;
            ex_fwd_b_q <= '0;
        end else begin
            v_q <= {v_q[NUM_STAGES-2:0], ins_v_d};
            if (bubble) begin
                ex_fwd_a_q <= '0;
                ex_fwd_b_q <= '0;
            end else begin
                ex_fwd_a_q <= sel_d[0];
                ex_fwd_b_q <= sel_d[1];
            end
        end
    end

    // NOTE: rd/ld payload is left unreset; it is only ever read qualified by its v bit.
    always_ff @(posedge clk) begin
        rd_q[0] <= id_rd;
        ld_q    <= {ld_q[NUM_STAGES-2:0], id_is_load};
        for (int s = 1; s < NUM_STAGES; s++) begin
            rd_q[s] <= rd_q[s-1];
        end
    end

    assign ex_fwd_a = ex_fwd_a_q;
    assign ex_fwd_b = ex_fwd_b_q;
    assign inflight = v_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_events_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (stall && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (flush && (flush_events_q != '1)) flush_events_q <= flush_events_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: a default instance (3 stages, LOAD_LAT=1) and a deep instance
// (6 stages, LOAD_LAT=3) share stimulus; each phase checks the instance it targets.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used;
    logic       id_regwrite, id_is_load;
    logic       flush;

    logic       stall0, stall1;
    logic [1:0] fwd_a0, fwd_b0;
    logic [2:0] fwd_a1, fwd_b1;
    logic [2:0] inflight0;
    logic [5:0] inflight1;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles0, flush_events0, stall_cycles1, flush_events1;
`endif

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.RF_ADDRESS(5), .NUM_STAGES(3), .LOAD_LAT(1)) u0 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_cycles0), .flush_events(flush_events0),
`endif
        .stall(stall0), .ex_fwd_a(fwd_a0), .ex_fwd_b(fwd_b0), .inflight(inflight0)
    );

    pipe_hazard_ctrl #(.RF_ADDRESS(5), .NUM_STAGES(6), .LOAD_LAT(3)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_cycles1), .flush_events(flush_events1),
`endif
        .stall(stall1), .ex_fwd_a(fwd_a1), .ex_fwd_b(fwd_b1), .inflight(inflight1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1_, input logic [4:0] rs2,
                         input logic u2_, input logic [4:0] rd, input logic rw, input logic ld,
                         input logic fl);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1_;
        id_rs2      = rs2;
        id_rs2_used = u2_;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
        flush       = fl;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Registered outputs are valid 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (6) cyc();
    endtask

    initial begin
        // Reset with a live, random decode instruction
        reset = 1'b0;
        drive(1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 1'($urandom), 1'b0);
        cyc();
        cyc();
        #1;
        check("rst_stall0", 32'(stall0), 0);
        check("rst_fwd_a0", 32'(fwd_a0), 0);
        check("rst_fwd_b0", 32'(fwd_b0), 0);
        check("rst_inflight0", 32'(inflight0), 0);
        check("rst_stall1", 32'(stall1), 0);
        check("rst_inflight1", 32'(inflight1), 0);
        reset = 1'b1;
        nop();
        cyc();

        // ALU back-to-back: add x5,x1,x2 ; add x6,x5,x7
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        #1 check("alu_prod_stall", 32'(stall0), 0);
        cyc();
        check("alu_inflight", 32'(inflight0), 32'b001);
        drive(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 check("alu_cons_stall", 32'(stall0), 0);
        cyc();
        check("alu_fwd_a", 32'(fwd_a0), 2);
        check("alu_fwd_b", 32'(fwd_b0), 0);
        drain();

        // ALU with one gap: add x5 ; nop ; add x6,x0,x5 -> writer sits in stage 3 at consumer EX
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc();
        nop();
        cyc();
        drive(1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 check("gap_stall", 32'(stall0), 0);
        cyc();
        check("gap_fwd_a", 32'(fwd_a0), 0);
        check("gap_fwd_b", 32'(fwd_b0), 3);
        drain();

        // Load-use with LOAD_LAT=1: lw x5 ; add x6,x5,x5
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 check("ld_stall_c1", 32'(stall0), 1);
        cyc();
        check("ld_bubble_fwd_a", 32'(fwd_a0), 0);
        #1 check("ld_stall_c2", 32'(stall0), 0);
        cyc();
        check("ld_fwd_a", 32'(fwd_a0), 3);
        check("ld_fwd_b", 32'(fwd_b0), 3);
        drain();

        // Youngest wins: add x4 ; add x4 ; sub x1,x4,x0 ; then a load to x0
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        #1 check("yw_stall", 32'(stall0), 0);
        cyc();
        check("yw_fwd_a", 32'(fwd_a0), 2);
        check("yw_fwd_b", 32'(fwd_b0), 0);
        check("yw_inflight", 32'(inflight0), 32'b111);
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cyc();
        check("x0_inflight", 32'(inflight0), 32'b110);
        drain();

        // Reset in the middle of a load-use stall
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 check("mid_stall0", 32'(stall0), 1);
        check("mid_stall1", 32'(stall1), 1);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("mid_rst_inflight0", 32'(inflight0), 0);
        check("mid_rst_fwd_a0", 32'(fwd_a0), 0);
        #1 check("mid_rst_stall0", 32'(stall0), 0);
        check("mid_rst_stall1", 32'(stall1), 0);
        cyc();
        drain();

        // Flush on the would-be stall cycle: lw x5 ; add x6,x5,x0 with flush
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
        #1 check("fl_stall0", 32'(stall0), 0);
        check("fl_stall1", 32'(stall1), 0);
        cyc();
        check("fl_fwd_a", 32'(fwd_a0), 0);
        check("fl_inflight", 32'(inflight0), 32'b010);
`ifdef HAZARD_PERF_CNT_EN
        check("fl_flush_events", flush_events0, 1);
        check("fl_stall_cycles", stall_cycles0, 0);
`endif
        drain();

        // Deep instance, LOAD_LAT=3: lw x9 ; add x10,x9,x0 -> three stall cycles, then select 5
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("deep_stall_%0d", i), 32'(stall1), 1);
            cyc();
            check($sformatf("deep_bubble_fwd_%0d", i), 32'(fwd_a1), 0);
        end
        #1 check("deep_stall_clear", 32'(stall1), 0);
        cyc();
        check("deep_fwd_a", 32'(fwd_a1), 5);
        check("deep_fwd_b", 32'(fwd_b1), 0);
`ifdef HAZARD_PERF_CNT_EN
        check("deep_stall_cycles", stall_cycles1, 3);
`endif
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
